// File: rtl/nine_segment_animator_if.sv
// nine_segment_animator_if: frame write port, playback controls and frame outputs of the animator.
interface nine_segment_animator_if #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 24
);
    localparam int AW = $clog2(DEPTH);
    logic              wr_valid;
    logic [8:0]        wr_pattern;
    logic              wr_ready;
    logic              clear;
    logic              start;
    logic              stop;
    logic              pause;
    logic              loop;
    logic [HOLD_W-1:0] hold_cycles;
    logic [8:0]        segments;
    logic [AW-1:0]     frame_idx;
    logic [AW:0]       count;
    logic              playing;
    logic              done;
    modport master (
        output wr_valid, wr_pattern, clear, start, stop, pause, loop, hold_cycles,
        input  wr_ready, segments, frame_idx, count, playing, done
    );
    modport slave (
        input  wr_valid, wr_pattern, clear, start, stop, pause, loop, hold_cycles,
        output wr_ready, segments, frame_idx, count, playing, done
    );
endinterface

// File: rtl/nine_segment_animator.sv
// nine_segment_animator: stores 9-bit frames and plays them back with a programmable per-frame hold.
module nine_segment_animator #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    nine_segment_animator_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {IDLE, PLAY, PAUSE} state_t;
    state_t            state_q, state_d;
    logic [8:0]        mem_q [DEPTH];
    logic [8:0]        segments_q, segments_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     count_q, count_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d, hold_q, hold_d;
    logic              loop_q, loop_d, load_q, load_d, done_q, done_d;
    logic              wr_ready, playing, wr_en;
    assign wr_en = bus.wr_valid && wr_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            segments_q <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            hold_q     <= HOLD_W'(1);
            loop_q     <= 1'b0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            segments_q <= segments_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            loop_q     <= loop_d;
            load_q     <= load_d;
            done_q     <= done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[count_q[AW-1:0]] <= bus.wr_pattern;
    end
    // The first PLAY cycle only fetches frame 0, so the hold count starts once it is on segments.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        loop_d  = loop_q;
        load_d  = load_q;
        done_d  = 1'b0;
        count_d = count_q + CW'(wr_en);
        if (bus.clear) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            count_d = '0;
            load_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (bus.start && count_q != '0) begin
                state_d = PLAY;
                idx_d   = '0;
                cnt_d   = '0;
                load_d  = 1'b1;
                loop_d  = bus.loop;
                hold_d  = (bus.hold_cycles == '0) ? HOLD_W'(1) : bus.hold_cycles;
            end
        end else if (bus.stop) begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            load_d  = 1'b0;
        end else if (bus.pause) begin
            state_d = PAUSE;
        end else begin
            state_d = PLAY;
            if (load_q) begin
                load_d = 1'b0;
            end else if (cnt_q == hold_q - HOLD_W'(1)) begin
                cnt_d = '0;
                if ({1'b0, idx_q} < count_q - CW'(1)) begin
                    idx_d = idx_q + AW'(1);
                end else if (loop_q) begin
                    idx_d = '0;
                end else begin
                    state_d = IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + HOLD_W'(1);
            end
        end
        segments_d = (state_d != IDLE && !load_d) ? mem_q[idx_d] : '0;
    end
    always_comb begin
        wr_ready = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !bus.clear;
        playing  = (state_q != IDLE);
    end
    assign bus.wr_ready  = wr_ready;
    assign bus.playing   = playing;
    assign bus.segments  = segments_q;
    assign bus.frame_idx = idx_q;
    assign bus.count     = count_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_nine_segment_animator.sv
// tb_nine_segment_animator: scoreboard bench for the frame animator.
module tb_nine_segment_animator;
    localparam int DEPTH  = 8;
    localparam int HOLD_W = 24;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] sb_q [$];
    logic [8:0] fr [3] = '{9'h1FF, 9'h111, 9'h0AA};
    nine_segment_animator_if #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) bus ();
    nine_segment_animator #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Expected word per cycle: {playing, done, frame_idx, segments}.
    task automatic push(input logic p, input logic d, input int idx, input logic [8:0] seg);
        logic [2:0] i3;
        i3 = idx[2:0];
        sb_q.push_back({p, d, i3, seg});
    endtask
    task automatic write_frame(input logic [8:0] p);
        bus.wr_valid = 1'b1;
        bus.wr_pattern = p;
        tick();
        bus.wr_valid = 1'b0;
    endtask
    task automatic start_play(input int hold, input logic lp);
        bus.hold_cycles = HOLD_W'(hold);
        bus.loop = lp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask
    task automatic drain(input int pause_at, input int pause_len, input int stop_at);
        int k;
        logic [13:0] e;
        k = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("play%0d", k), {bus.playing, bus.done, bus.frame_idx, bus.segments}, e);
            if (k == pause_at) bus.pause = 1'b1;
            else if (k == pause_at + pause_len) bus.pause = 1'b0;
            bus.stop = (k == stop_at);
            k++;
            tick();
        end
        bus.pause = 1'b0;
        bus.stop = 1'b0;
    endtask
    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_pattern = '0;
        bus.clear = 1'b0;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.pause = 1'b0;
        bus.loop = 1'b0;
        bus.hold_cycles = '0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_seg", bus.segments, 0);
        check("rst_cnt", bus.count, 0);
        check("rst_rdy", bus.wr_ready, 1);
        check("rst_play", bus.playing, 0);
        check("rst_done", bus.done, 0);
        for (int i = 0; i < 3; i++) begin
            check("wr_rdy", bus.wr_ready, 1);
            write_frame(fr[i]);
            check("wr_cnt", bus.count, i + 1);
            check("wr_seg", bus.segments, 0);
        end
        start_play(4, 1'b0);
        push(1, 0, 0, 9'h0);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 4; j++) push(1, 0, i, fr[i]);
        push(0, 1, 0, 9'h0);
        push(0, 0, 0, 9'h0);
        drain(-1, 0, -1);
        start_play(0, 1'b1);
        push(1, 0, 0, 9'h0);
        for (int i = 0; i < 7; i++) push(1, 0, i % 3, fr[i % 3]);
        push(0, 0, 0, 9'h0);
        drain(-1, 0, 7);
        start_play(5, 1'b0);
        push(1, 0, 0, 9'h0);
        for (int i = 0; i < 12; i++) push(1, 0, 0, fr[0]);
        for (int i = 0; i < 2; i++) push(1, 0, 1, fr[1]);
        push(0, 0, 0, 9'h0);
        drain(3, 7, 14);
        pulse_clear();
        check("clr_cnt", bus.count, 0);
        for (int i = 0; i < DEPTH; i++) write_frame(9'(i * 37 + 1));
        check("full_cnt", bus.count, DEPTH);
        check("full_rdy", bus.wr_ready, 0);
        write_frame(9'h1AB);
        check("ovf_cnt", bus.count, DEPTH);
        pulse_clear();
        write_frame(9'h0F0);
        check("one_cnt", bus.count, 1);
        bus.clear = 1'b1;
        bus.wr_valid = 1'b1;
        #1;
        check("clr_rdy", bus.wr_ready, 0);
        tick();
        bus.clear = 1'b0;
        bus.wr_valid = 1'b0;
        check("clr_wr_cnt", bus.count, 0);
        write_frame(9'h155);
        start_play(2, 1'b1);
        push(1, 0, 0, 9'h0);
        for (int i = 0; i < 6; i++) push(1, 0, 0, 9'h155);
        push(0, 0, 0, 9'h0);
        drain(-1, 0, 6);
        write_frame(9'h00F);
        start_play(10, 1'b0);
        repeat (3) tick();
        check("pre_rst_seg", bus.segments, 9'h155);
        #2;
        rst = 1'b1;
        #1;
        check("arst_seg", bus.segments, 0);
        check("arst_cnt", bus.count, 0);
        check("arst_rdy", bus.wr_ready, 1);
        check("arst_play", bus.playing, 0);
        tick();
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("empty_play", bus.playing, 0);
        check("empty_seg", bus.segments, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/nine_segment_animator.md
Name: nine_segment_animator

Overview:
- Upstream pattern source for the 3x3 LED row/column scanning driver.
- Stores a short sequence of 9-bit frames, loaded through a valid/ready write port.
- Plays the frames back on the `segments` bus. Each frame is held for a programmable number of clock cycles. Playback is one-shot or looping.
- `segments` bit order: bit 8 = top-left … bit 0 = bottom-right. Bits 8..6 are the top row and bits 2..0 the bottom row, matching the scan driver's expectation.

Parameters:
- DEPTH, 8: frame buffer entries. Power of two, minimum 2.
- HOLD_W, 24: width of the hold-cycle count.

Ports:
- clk  in  1  single system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  frame write request.
- wr_pattern  in  9  frame data; bit 8 = top-left.
- wr_ready  out  1  buffer can accept a frame this cycle.
- clear  in  1  pulse; empties the buffer and aborts playback.
- start  in  1  pulse; begins playback from frame 0.
- stop  in  1  pulse; ends playback.
- pause  in  1  level; freezes playback while high.
- loop  in  1  level, sampled at start; 1 = wrap forever, 0 = one pass.
- hold_cycles  in  HOLD_W  cycles per frame, sampled at start; 0 is treated as 1.
- segments  out  9  current frame to the scan driver. Registered.
- frame_idx  out  $clog2(DEPTH)  index of the frame on `segments`.
- count  out  $clog2(DEPTH)+1  number of frames stored.
- playing  out  1  high in PLAY or PAUSE.
- done  out  1  one-cycle pulse when a one-shot pass completes.

Behaviour:
- Reset (async assert, any state):
  - state = IDLE; segments = 0; frame_idx = 0; count = 0.
  - Hold counter = 0; playing = 0; done = 0; wr_ready = 1.
  - Buffer contents are don't-care.
- wr_ready = (state == IDLE) && (count < DEPTH) && !clear. Combinational.
- Write:
  - Accepted when wr_valid && wr_ready. Stores wr_pattern into buf[count]; count increments next cycle.
  - wr_valid with wr_ready low is ignored. The sender holds data until accepted.
- clear:
  - Honoured in any state. Next cycle: count = 0, state = IDLE, segments = 0, frame_idx = 0, hold counter = 0.
  - clear wins over a same-cycle write, start, or stop.
  - No done pulse is issued.
- States:
  - IDLE: segments = 0; playing = 0.
    - start && count > 0 → PLAY. Latches loop and max(hold_cycles, 1); frame_idx = 0; hold counter = 0.
    - start with count == 0 is ignored.
  - PLAY: segments = buf[frame_idx], registered.
    - Latency: start seen at edge N → segments = buf[0] after edge N+1.
    - Each frame is visible for exactly the latched hold value H cycles.
    - When hold counter == H-1: counter resets to 0.
      - If frame_idx < count-1: frame_idx increments.
      - Else, if looping: frame_idx = 0.
      - Else (one-shot): → IDLE, segments = 0, done = 1 for one cycle.
    - pause high → PAUSE. Counter, frame_idx and segments are frozen.
  - PAUSE: holds all values; playing = 1.
    - pause low → PLAY. Counting resumes from the frozen counter value; no cycles are lost or added.
- stop in PLAY or PAUSE → IDLE next cycle: segments = 0, frame_idx = 0, no done pulse.
- Priority: clear > stop > pause > start. start in PLAY or PAUSE is ignored, so there is no restart.
- Changes to hold_cycles or loop during playback have no effect until the next start.
- DEPTH == count: wr_ready is low. Playback is still allowed.
- count == 1 with loop = 1: segments is constant buf[0]; frame_idx stays 0.
- Hold counter is HOLD_W bits and never exceeds H-1. It does not overflow, even at H = 2^HOLD_W-1.

Test Plan:
- Reset, then write 3 frames 0x1FF, 0x111, 0x0AA. Expect count 0→3, wr_ready high throughout, segments = 0.
- Frames above, hold_cycles = 4, loop = 0, start:
  - segments = 0x1FF for 4 cycles, 0x111 for 4, then 0x0AA for 4.
  - Then segments = 0 and done pulses exactly once; state IDLE.
- Same frames, hold_cycles = 0, loop = 1:
  - segments changes every cycle: 0x1FF, 0x111, 0x0AA, 0x1FF, …
  - frame_idx wraps 2→0; done never asserted.
- Write 8 frames (DEPTH = 8):
  - wr_ready drops after the 8th accept; a 9th wr_valid is ignored and count stays 8.
  - clear together with wr_valid → count = 0, write not accepted.
- hold_cycles = 5, pause high for 7 cycles starting in the 3rd cycle of frame 0:
  - Frame 0 is visible 5+7 = 12 cycles total, then frame 1 appears.
  - stop during frame 1 → segments = 0 next cycle, no done.
- rst asserted asynchronously mid-frame in PLAY:
  - segments = 0, count = 0, wr_ready = 1 immediately, without waiting for a clock edge.
  - start with count == 0 after reset release stays in IDLE.
